tick_controller: RTL and testbench
==================================

TICK_CONTROLLER -- requirements
Module: tick_controller

Interface
REQ-001 SHALL have parameter DivBits, default 16, width of the tick divider.
REQ-002 SHALL have parameter CountBits, default 32, width of the issued-tick counter.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high; one clock, no other clock or asynchronous reset.
REQ-005 SHALL have port Run  input  1  level; free-run request.
REQ-006 SHALL have port Step  input  1  single-step request; acts on rising edge only.
REQ-007 SHALL have port Halt  input  1  level; CPU halt (ecall/halt decode).
REQ-008 SHALL have port Div  input  DivBits  tick period minus one.
REQ-009 SHALL have port Tick  output  1  registered one-cycle enable driven to every register's Tick input.
REQ-010 SHALL have port Running  output  1  registered; high while state is RUN.
REQ-011 SHALL have port Halted  output  1  registered; high while state is HALTED.
REQ-012 SHALL have port CycleCount  output  CountBits  registered count of Tick pulses issued.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STEP, HALTED.
REQ-014 SHALL detect a Step edge as Step=1 this cycle and registered Step=0 last cycle.
REQ-015 IDLE: Halt=1 -> HALTED; else Step edge -> STEP; else Run=1 -> RUN; else stay. Halt > Step > Run.
REQ-016 STEP: Tick=1 for exactly one cycle (the cycle after entry), then -> IDLE; Halt sampled in IDLE-to-STEP cycle -> HALTED, no Tick.
REQ-017 RUN: divider counter cleared to 0 on entry, increments each cycle; when counter equals Div, schedule Tick for next cycle and clear counter.
REQ-018 With Div=N, first Tick SHALL be high N+1 cycles after RUN entry (edge into RUN = cycle 0), then every N+1 cycles; Div=0 gives Tick every cycle from cycle 1.
REQ-019 Div changes mid-period SHALL take effect at the current comparison (compare is against live Div); if counter > new Div, counter SHALL count up and wrap at 2^DivBits to 0 before matching.
REQ-020 RUN with Run=0 and Halt=0 -> IDLE, counter cleared, no Tick scheduled that cycle; a Tick already high completes.
REQ-021 Step edges in RUN or STEP SHALL be ignored.
REQ-022 Halt=1 in any non-HALTED state -> HALTED next cycle; no Tick scheduled from the sampling cycle on; an already-high Tick is not cancelled.
REQ-023 HALTED SHALL be left only by Reset; Tick stays 0.
REQ-024 CycleCount SHALL increment by 1 on every cycle Tick=1, wrapping from all-ones to 0.
REQ-025 Running/Halted SHALL reflect the state register (one-cycle lag from transition decision).

Reset
REQ-026 Reset=1 at a clock edge SHALL force IDLE, Tick=0, Running=0, Halted=0, CycleCount=0, divider counter=0, registered Step=0, overriding all inputs including Halt.
REQ-027 Reset asserted mid-RUN or in HALTED SHALL take effect at the same edge; no Tick in the following cycle.
REQ-028 After Reset falls, Step held high SHALL NOT count as an edge until it goes low then high.

Verification
REQ-029 Reset 2 cycles, Run=0, Step=0 -> Tick=0, CycleCount=0, Running=0, Halted=0 for 10 cycles.
REQ-030 Div=0, Run=1 for 8 cycles then Run=0 -> Tick high 8 consecutive cycles starting cycle 1, CycleCount=8, Running low after.
REQ-031 Div=3, Run=1 for 20 cycles -> Tick at cycles 4, 8, 12, 16, 20 only; CycleCount=5.
REQ-032 IDLE, Step pulsed 3 times (held 2 cycles each, gaps 3 cycles) -> exactly 3 single-cycle Ticks, CycleCount=3; Step held 10 cycles -> one Tick.
REQ-033 Div=1, Run=1, Halt=1 at cycle 5 -> Ticks at cycles 2, 4 only, Halted=1 from cycle 6, Run/Step ignored until Reset, then IDLE.
REQ-034 CountBits=4, Div=0, Run=1 for 17 cycles -> CycleCount sequence wraps 15 -> 0, ends at 1; Reset at cycle 10 of a second run -> CycleCount=0, Tick=0 next cycle.

Source files
------------

// File: rtl/tick_controller.sv
// Tick controller: gates the register-file Tick enable
// for free-run, single-step and halt operation.
module tick_controller #(
  parameter int DivBits   = 16,
  parameter int CountBits = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Step,
  input  logic                 Halt,
  input  logic [DivBits-1:0]   Div,
  output logic                 Tick,
  output logic                 Running,
  output logic                 Halted,
  output logic [CountBits-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } state_t;

  localparam logic [DivBits-1:0]   DivOne = 1;
  localparam logic [CountBits-1:0] CntOne = 1;

  state_t             state;
  logic               step_q;
  logic               step_arm;
  logic               step_edge;
  logic               hit;
  logic [DivBits-1:0] div_cnt;

  // A Step held across reset must drop before it can fire.
  assign step_edge = Step & ~step_q & step_arm;

  // Compare against the live Div so changes act at once.
  assign hit = (div_cnt == Div);

  // Step edge history; the arm bit is cleared by reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q   <= 1'b0;
      step_arm <= 1'b0;
    end else begin
      step_q <= Step;
      if (!Step)
        step_arm <= 1'b1;
    end
  end

  // Control FSM with registered Tick/Running/Halted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      Tick    <= 1'b0;
      Running <= 1'b0;
      Halted  <= 1'b0;
      div_cnt <= '0;
    end else begin
      Tick <= 1'b0;
      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          if (Halt) begin
            state  <= HALTED;
            Halted <= 1'b1;
          end else if (step_edge) begin
            state <= STEP;
          end else if (Run) begin
            state   <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (Halt) begin
            state   <= HALTED;
            Running <= 1'b0;
            Halted  <= 1'b1;
            div_cnt <= '0;
          end else if (!Run) begin
            state   <= IDLE;
            Running <= 1'b0;
            div_cnt <= '0;
          end else if (hit) begin
            Tick    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DivOne;
          end
        end
        STEP: begin
          if (Halt) begin
            state  <= HALTED;
            Halted <= 1'b1;
          end else begin
            state <= IDLE;
            Tick  <= 1'b1;
          end
        end
        HALTED: begin
          Halted <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Halted  <= 1'b0;
        end
      endcase
    end
  end

  // Count every cycle on which Tick was high.
  always_ff @(posedge Clock) begin
    if (Reset)
      CycleCount <= '0;
    else if (Tick)
      CycleCount <= CycleCount + CntOne;
  end

endmodule

// File: tb/tb_tick_controller.sv
// Bench for tick_controller: directed steps with a
// scoreboard queue, default and 4-bit instances.
module tb_tick_controller;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic        Step;
  logic        Halt;
  logic [15:0] Div;

  logic        Tick;
  logic        Running;
  logic        Halted;
  logic [31:0] CycleCount;

  logic        Tick4;
  logic        Running4;
  logic        Halted4;
  logic [3:0]  Count4;

  int          ncmp;
  int          nfail;
  logic [31:0] ecnt;
  logic [3:0]  ecnt4;
  logic [41:0] sbq[$];
  string       tagq[$];

  tick_controller u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Run        (Run),
    .Step       (Step),
    .Halt       (Halt),
    .Div        (Div),
    .Tick       (Tick),
    .Running    (Running),
    .Halted     (Halted),
    .CycleCount (CycleCount)
  );

  tick_controller #(
    .DivBits   (4),
    .CountBits (4)
  ) u_dut4 (
    .Clock      (Clock),
    .Reset      (Reset),
    .Run        (Run),
    .Step       (Step),
    .Halt       (Halt),
    .Div        (Div[3:0]),
    .Tick       (Tick4),
    .Running    (Running4),
    .Halted     (Halted4),
    .CycleCount (Count4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One clock: drive inputs, push the expected outputs
  // for after the edge, then pop and compare.
  task automatic cyc(
    input string tag,
    input logic  rs, rn, st, hl,
    input logic  et, et4, er, eh
  );
    logic [41:0] exp_v;
    logic [41:0] obs_v;
    string       tg;
    Reset = rs;
    Run   = rn;
    Step  = st;
    Halt  = hl;
    if (rs) begin
      ecnt  = '0;
      ecnt4 = '0;
    end
    sbq.push_back({et, et4, er, eh, er, eh, ecnt, ecnt4});
    tagq.push_back(tag);
    if (et)
      ecnt = ecnt + 32'd1;
    if (et4)
      ecnt4 = ecnt4 + 4'd1;
    @(posedge Clock);
    #1;
    exp_v = sbq.pop_front();
    tg    = tagq.pop_front();
    obs_v = {Tick, Tick4, Running, Halted,
             Running4, Halted4, CycleCount, Count4};
    ncmp++;
    assert (obs_v === exp_v)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tg, obs_v, exp_v);
    end
  endtask

  // Free run for edges 0..n, then drop Run.
  task automatic run_seq(
    input string tag,
    input int    dv,
    input int    n
  );
    logic et;
    Div = dv[15:0];
    for (int k = 0; k <= n; k++) begin
      et = (k > 0) && ((k % (dv + 1)) == 0);
      cyc(tag, 0, 1, 0, 0, et, et, 1, 0);
    end
    cyc({tag, "_stop"}, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc({tag, "_idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic et;
    ncmp  = 0;
    nfail = 0;
    ecnt  = '0;
    ecnt4 = '0;
    Div   = '0;

    // Reset then quiet idle.
    repeat (2) cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Div=0 and Div=3 free runs.
    run_seq("div0", 0, 8);
    run_seq("div3", 3, 20);

    // Three 2-cycle Step pulses, then one long hold.
    repeat (3) begin
      cyc("step_a", 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("step_t", 0, 0, 1, 0, 1, 1, 0, 0);
      repeat (3) cyc("step_g", 0, 0, 0, 0, 0, 0, 0, 0);
    end
    cyc("hold_a", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("hold_t", 0, 0, 1, 0, 1, 1, 0, 0);
    repeat (8) cyc("hold_h", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("hold_r", 0, 0, 0, 0, 0, 0, 0, 0);

    // Div lowered below the counter: the 4-bit
    // divider wraps at 16, the 16-bit one does not.
    Div = 16'd4;
    for (int k = 0; k <= 8; k++)
      cyc("dchg_a", 0, 1, 0, 0, k == 5, k == 5, 1, 0);
    Div = 16'd1;
    for (int k = 9; k <= 23; k++)
      cyc("dchg_b", 0, 1, 0, 0, 0, k == 23, 1, 0);
    cyc("dchg_s", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("dchg_r", 1, 0, 0, 0, 0, 0, 0, 0);

    // Halt during a Div=1 run.
    Div = 16'd1;
    for (int k = 0; k <= 5; k++) begin
      et = (k == 2) || (k == 4);
      cyc("halt_run", 0, 1, 0, 0, et, et, 1, 0);
    end
    cyc("halt_in", 0, 1, 0, 1, 0, 0, 0, 1);
    cyc("halt_r", 0, 1, 0, 0, 0, 0, 0, 1);
    cyc("halt_s0", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("halt_s1", 0, 0, 1, 0, 0, 0, 0, 1);
    cyc("halt_s2", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("halt_s3", 0, 1, 1, 0, 0, 0, 0, 1);
    cyc("halt_rs", 1, 1, 1, 1, 0, 0, 0, 0);

    // Step held through reset is not an edge.
    repeat (3) cyc("post_rs", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("post_lo", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_hi", 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("post_tk", 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("post_q", 0, 0, 0, 0, 0, 0, 0, 0);

    // Halt beats a simultaneous Step edge in IDLE.
    cyc("hs_in", 0, 0, 1, 1, 0, 0, 0, 1);
    cyc("hs_q", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("hs_rs", 1, 0, 0, 0, 0, 0, 0, 0);

    // 17 ticks wrap the 4-bit counter to 1.
    run_seq("wrap", 0, 17);

    // Reset at cycle 10 of a second run.
    Div = 16'd0;
    for (int k = 0; k <= 9; k++)
      cyc("rsrun", 0, 1, 0, 0, k > 0, k > 0, 1, 0);
    cyc("rsrun_rs", 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("rsrun_e", 0, 1, 0, 0, 0, 0, 1, 0);
    cyc("rsrun_t", 0, 1, 0, 0, 1, 1, 1, 0);
    cyc("rsrun_s", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rsrun_q", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
